// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Instruction-fetch stage of the multi-cycle RV32I core. A fetch_start pulse issues one read
//   to instruction memory over a req/gnt/rvalid bus. The returned word is captured in the
//   instruction register and handed to the decoder with a valid/ready handshake. Flush,
//   misaligned pc and a memory timeout are handled here.
//
//   Ports
//     clk, rst_n                  clock (rising edge), async active-low reset
//     pc_in, fetch_start          fetch address and single-cycle fetch request
//     flush                       abandon the current fetch (redirect)
//     mem_req, mem_addr           read request / address to instruction memory
//     mem_gnt, mem_rvalid,
//     mem_rdata                   memory grant, read-data valid, read data
//     instr_valid, instr_ready    decoder handshake
//     instr, instr_pc             instruction register and the address it came from
//     misaligned_fault, bus_error single-cycle fault pulses
//     busy                        fetch in progress (REQ, WAIT, HOLD)
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no fetch outstanding, waiting for fetch_start
//   REQ    | mem_req asserted, waiting for mem_gnt
//   WAIT   | request granted, waiting for mem_rvalid (dropped if discard)
//   HOLD   | IR valid, waiting for the decoder to take it
module instr_fetch_unit #(
    parameter int              XLEN           = 32,
    parameter int              TIMEOUT_CYCLES = 16,
    parameter logic [XLEN-1:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_in,
    input  logic            fetch_start,
    input  logic            flush,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            misaligned_fault,
    output logic            bus_error,
    output logic            busy
);

    // One spare bit so the timer can run one past the limit (grant on the last REQ cycle,
    // or a flush on the limit cycle) without wrapping.
    localparam int            TW     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            discard_q, discard_d;
    logic [XLEN-1:0] mem_addr_d, instr_d, instr_pc_d;
    logic            valid_d, fault_d, berr_d;
    logic            aligned, timeout;

    assign aligned = (pc_in[1:0] == 2'b00);
    // ">=" rather than "==" so a grant on the final REQ cycle still times out in WAIT.
    assign timeout = (timer_q >= T_LAST);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        discard_d  = discard_q;
        mem_addr_d = mem_addr;
        instr_d    = instr;
        instr_pc_d = instr_pc;
        valid_d    = instr_valid;
        fault_d    = 1'b0;
        berr_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (fetch_start && !flush) begin
                    if (aligned) begin
                        state_d    = S_REQ;
                        mem_addr_d = pc_in;
                        timer_d    = '0;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end

            S_REQ: begin
                timer_d = timer_q + TW'(1);
                if (mem_gnt) begin
                    if (flush) begin
                        // Data already returning with the grant is simply dropped.
                        if (mem_rvalid) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d   = S_WAIT;
                            discard_d = 1'b1;
                        end
                    end else if (mem_rvalid) begin
                        state_d    = S_HOLD;
                        instr_d    = mem_rdata;
                        instr_pc_d = mem_addr;
                        valid_d    = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (flush) begin
                    state_d = S_IDLE;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    berr_d  = 1'b1;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end

            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (mem_rvalid) begin
                    if (discard_q || flush) begin
                        state_d   = S_IDLE;
                        discard_d = 1'b0;
                    end else begin
                        state_d    = S_HOLD;
                        instr_d    = mem_rdata;
                        instr_pc_d = mem_addr;
                        valid_d    = 1'b1;
                    end
                end else if (flush) begin
                    discard_d = 1'b1;
                end else if (timeout) begin
                    state_d   = S_IDLE;
                    discard_d = 1'b0;
                    // A fetch that was already abandoned ends quietly.
                    if (!discard_q) begin
                        berr_d  = 1'b1;
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end
            end

            S_HOLD: begin
                if (flush) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else if (instr_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    if (fetch_start) begin
                        if (aligned) begin
                            state_d    = S_REQ;
                            mem_addr_d = pc_in;
                            timer_d    = '0;
                        end else begin
                            fault_d = 1'b1;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            timer_q          <= '0;
            discard_q        <= 1'b0;
            mem_req          <= 1'b0;
            mem_addr         <= '0;
            instr            <= NOP_INSTR;
            instr_pc         <= '0;
            instr_valid      <= 1'b0;
            misaligned_fault <= 1'b0;
            bus_error        <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state_q          <= state_d;
            timer_q          <= timer_d;
            discard_q        <= discard_d;
            mem_req          <= (state_d == S_REQ);
            mem_addr         <= mem_addr_d;
            instr            <= instr_d;
            instr_pc         <= instr_pc_d;
            instr_valid      <= valid_d;
            misaligned_fault <= fault_d;
            bus_error        <= berr_d;
            busy             <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit. Inputs change on the falling edge, outputs are sampled on
// the falling edge (half a cycle after the registers update). The expected IR contents are
// tracked in exp_instr/exp_pc; expected timing is derived from the bus delays chosen per fetch.
module tb_instr_fetch_unit;
    localparam int          TO  = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_in = '0;
    logic        fetch_start = 1'b0;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misaligned_fault;
    logic        bus_error;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_instr = NOP;
    logic [31:0] exp_pc = '0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .fetch_start(fetch_start), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .misaligned_fault(misaligned_fault),
        .bus_error(bus_error), .busy(busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One complete fetch: grant after g REQ cycles, rvalid r cycles after grant (0 = same
    // cycle), decoder takes the IR after rdy extra cycles. Stray traffic is injected where the
    // unit must ignore it.
    task automatic run_fetch(input logic [31:0] pc, input logic [31:0] data,
                             input int g, input int r, input int rdy);
        @(negedge clk); pc_in = pc; fetch_start = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = ~data;
        @(negedge clk); fetch_start = 1'b0; mem_rvalid = 1'b0;
        for (int i = 0; i <= g; i++) begin
            total++;
            if (mem_req !== 1'b1 || mem_addr !== pc || busy !== 1'b1) begin
                bad++;
                $display("FAIL req_hold: req=%b addr=%h busy=%b, want req=1 addr=%h busy=1",
                         mem_req, mem_addr, busy, pc);
            end
            if (i == g) begin
                mem_gnt = 1'b1;
                if (r == 0) begin mem_rvalid = 1'b1; mem_rdata = data; end
            end else begin
                fetch_start = 1'b1; pc_in = $urandom & 32'hFFFF_FFFC;
            end
            @(negedge clk); fetch_start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        end
        total++;
        if (mem_req !== 1'b0) begin
            bad++; $display("FAIL req_drop: req=%b want 0", mem_req);
        end
        for (int j = 1; j <= r; j++) begin
            total++;
            if (instr_valid !== 1'b0) begin
                bad++; $display("FAIL early_valid: valid=%b want 0 (wait cycle %0d)", instr_valid, j);
            end
            if (j == r) begin
                mem_rvalid = 1'b1; mem_rdata = data;
            end else begin
                fetch_start = 1'b1; pc_in = pc + 32'd4;
            end
            @(negedge clk); mem_rvalid = 1'b0; fetch_start = 1'b0;
        end
        exp_instr = data; exp_pc = pc;
        total++;
        if (instr_valid !== 1'b1 || instr !== exp_instr || instr_pc !== exp_pc) begin
            bad++;
            $display("FAIL capture: valid=%b instr=%h pc=%h, want 1 %h %h",
                     instr_valid, instr, instr_pc, exp_instr, exp_pc);
        end
        for (int k = 0; k < rdy; k++) begin
            fetch_start = 1'b1; pc_in = pc + 32'd8;
            @(negedge clk); fetch_start = 1'b0;
            total++;
            if (instr_valid !== 1'b1 || instr !== exp_instr || mem_req !== 1'b0) begin
                bad++;
                $display("FAIL hold_valid: valid=%b instr=%h req=%b, want 1 %h 0",
                         instr_valid, instr, mem_req, exp_instr);
            end
        end
        instr_ready = 1'b1;
        @(negedge clk); instr_ready = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || busy !== 1'b0 || instr !== exp_instr) begin
            bad++;
            $display("FAIL consume: valid=%b busy=%b instr=%h, want 0 0 %h",
                     instr_valid, busy, instr, exp_instr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || instr !== NOP || instr_pc !== 32'h0 ||
            instr_valid !== 1'b0 || misaligned_fault !== 1'b0 || bus_error !== 1'b0 ||
            busy !== 1'b0) begin
            bad++;
            $display("FAIL reset: req=%b addr=%h instr=%h pc=%h valid=%b mf=%b be=%b busy=%b",
                     mem_req, mem_addr, instr, instr_pc, instr_valid, misaligned_fault,
                     bus_error, busy);
        end
        rst_n = 1'b1;
        exp_instr = NOP; exp_pc = '0;
    endtask

    task automatic test_basic();
        run_fetch(32'h0000_0100, 32'h0050_0093, 0, 1, 2);
    endtask

    task automatic test_wait_states();
        run_fetch(32'h0000_0100, 32'h0050_0093, 3, 2, 1);
        run_fetch(32'h0000_0100, 32'h0010_0113, 3, 0, 0);
    endtask

    task automatic test_misaligned();
        logic [31:0] pc;
        for (int n = 0; n < 3; n++) begin
            pc = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
            @(negedge clk); pc_in = pc; fetch_start = 1'b1;
            @(negedge clk); fetch_start = 1'b0;
            total++;
            if (misaligned_fault !== 1'b1 || mem_req !== 1'b0) begin
                bad++; $display("FAIL misaligned_pulse: mf=%b req=%b, want 1 0", misaligned_fault, mem_req);
            end
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                total++;
                if (misaligned_fault !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL misaligned_after: mf=%b req=%b busy=%b, want 0 0 0",
                             misaligned_fault, mem_req, busy);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pa, pb, da, db;
        pa = $urandom & 32'hFFFF_FFFC; pb = $urandom & 32'hFFFF_FFFC;
        da = $urandom; db = $urandom;
        @(negedge clk); pc_in = pa; fetch_start = 1'b1;
        @(negedge clk); fetch_start = 1'b0; mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = da;
        @(negedge clk); mem_rvalid = 1'b0;
        exp_instr = da; exp_pc = pa;
        instr_ready = 1'b1; fetch_start = 1'b1; pc_in = pb;
        @(negedge clk); instr_ready = 1'b0; fetch_start = 1'b0;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== pb || instr_valid !== 1'b0 || instr !== exp_instr) begin
            bad++;
            $display("FAIL b2b_req: req=%b addr=%h valid=%b instr=%h, want 1 %h 0 %h",
                     mem_req, mem_addr, instr_valid, instr, pb, exp_instr);
        end
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = db;
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b0;
        exp_instr = db; exp_pc = pb;
        total++;
        if (instr_valid !== 1'b1 || instr !== exp_instr || instr_pc !== exp_pc) begin
            bad++;
            $display("FAIL b2b_capture: valid=%b instr=%h pc=%h, want 1 %h %h",
                     instr_valid, instr, instr_pc, exp_instr, exp_pc);
        end
        instr_ready = 1'b1; fetch_start = 1'b1; pc_in = pb | 32'h2;
        @(negedge clk); instr_ready = 1'b0; fetch_start = 1'b0;
        total++;
        if (misaligned_fault !== 1'b1 || mem_req !== 1'b0 || instr_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_misaligned: mf=%b req=%b valid=%b busy=%b, want 1 0 0 0",
                     misaligned_fault, mem_req, instr_valid, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic [31:0] pc, d;
        int          n, berr_seen;
        pc = $urandom & 32'hFFFF_FFFC;
        // flush in WAIT, late data must be dropped
        @(negedge clk); pc_in = pc; fetch_start = 1'b1;
        @(negedge clk); fetch_start = 1'b0; mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        n = $urandom_range(0, 3);
        repeat (n) @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk); mem_rvalid = 1'b0;
        total++;
        if (instr !== exp_instr || instr_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_wait: instr=%h valid=%b busy=%b, want %h 0 0",
                     instr, instr_valid, busy, exp_instr);
        end
        // flush in REQ before grant
        @(negedge clk); pc_in = pc; fetch_start = 1'b1;
        @(negedge clk); fetch_start = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        total++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL flush_req: req=%b busy=%b, want 0 0", mem_req, busy);
        end
        // flush together with grant
        @(negedge clk); pc_in = pc; fetch_start = 1'b1;
        @(negedge clk); fetch_start = 1'b0; flush = 1'b1; mem_gnt = 1'b1;
        @(negedge clk); flush = 1'b0; mem_gnt = 1'b0;
        total++;
        if (mem_req !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL flush_gnt_wait: req=%b busy=%b, want 0 1", mem_req, busy);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk); mem_rvalid = 1'b0;
        total++;
        if (instr !== exp_instr || instr_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_gnt_drop: instr=%h valid=%b busy=%b, want %h 0 0",
                     instr, instr_valid, busy, exp_instr);
        end
        // flush in HOLD
        d = $urandom;
        @(negedge clk); pc_in = pc; fetch_start = 1'b1;
        @(negedge clk); fetch_start = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = d;
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b0;
        exp_instr = d; exp_pc = pc;
        total++;
        if (instr_valid !== 1'b1 || instr !== exp_instr) begin
            bad++; $display("FAIL flush_hold_pre: valid=%b instr=%h, want 1 %h", instr_valid, instr, exp_instr);
        end
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || busy !== 1'b0 || instr !== exp_instr || instr_pc !== exp_pc) begin
            bad++;
            $display("FAIL flush_hold: valid=%b busy=%b instr=%h, want 0 0 %h",
                     instr_valid, busy, instr, exp_instr);
        end
        // flush beats fetch_start in IDLE
        flush = 1'b1; fetch_start = 1'b1; pc_in = pc;
        @(negedge clk); flush = 1'b0; fetch_start = 1'b0;
        total++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL flush_idle_start: req=%b busy=%b, want 0 0", mem_req, busy);
        end
        // abandoned fetch that never returns data times out silently
        @(negedge clk); pc_in = pc; fetch_start = 1'b1;
        @(negedge clk); fetch_start = 1'b0; mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        berr_seen = 0;
        for (int c = 0; c < 40 && busy === 1'b1; c++) begin
            @(negedge clk);
            if (bus_error === 1'b1) berr_seen++;
        end
        total++;
        if (busy !== 1'b0 || berr_seen != 0 || instr !== exp_instr) begin
            bad++;
            $display("FAIL flush_timeout: busy=%b bus_error_cycles=%0d instr=%h, want 0 0 %h",
                     busy, berr_seen, instr, exp_instr);
        end
    endtask

    // Timeout after TO cycles in REQ+WAIT: bus_error is visible on cycle TO+1 after the
    // fetch_start cycle. mode 0: never granted; otherwise granted after g cycles, no data.
    task automatic test_timeout();
        int g, first_be, be_cycles, req_cycles, want_req;
        for (int mode = 0; mode < 3; mode++) begin
            g = (mode == 0) ? -1 : $urandom_range(0, TO - 2);
            want_req = (mode == 0) ? TO : g + 1;
            @(negedge clk); pc_in = $urandom & 32'hFFFF_FFFC; fetch_start = 1'b1;
            @(negedge clk); fetch_start = 1'b0;
            first_be = 0; be_cycles = 0; req_cycles = 0;
            for (int c = 1; c <= TO + 6; c++) begin
                if (mem_req === 1'b1) req_cycles++;
                if (bus_error === 1'b1) begin
                    be_cycles++;
                    if (first_be == 0) first_be = c;
                    total++;
                    if (mem_req !== 1'b0 || instr !== NOP || instr_valid !== 1'b0 || busy !== 1'b0) begin
                        bad++;
                        $display("FAIL timeout_state: req=%b instr=%h valid=%b busy=%b, want 0 %h 0 0",
                                 mem_req, instr, instr_valid, busy, NOP);
                    end
                end
                mem_gnt = (c == g + 1);
                @(negedge clk); mem_gnt = 1'b0;
            end
            exp_instr = NOP;
            total++;
            if (first_be != TO + 1 || be_cycles != 1 || req_cycles != want_req) begin
                bad++;
                $display("FAIL timeout_timing: first=%0d width=%0d req_cycles=%0d, want %0d 1 %0d",
                         first_be, be_cycles, req_cycles, TO + 1, want_req);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            run_fetch($urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(0, 4),
                      $urandom_range(0, 4), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk); pc_in = 32'h0000_0100; fetch_start = 1'b1;
        @(negedge clk); fetch_start = 1'b0; mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0 || instr !== NOP || instr_valid !== 1'b0 || busy !== 1'b0 ||
            mem_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid_wait: req=%b instr=%h valid=%b busy=%b addr=%h, want 0 %h 0 0 0",
                     mem_req, instr, instr_valid, busy, mem_addr, NOP);
        end
        @(negedge clk); rst_n = 1'b1;
        exp_instr = NOP; exp_pc = '0;
        run_fetch(32'h0000_0200, 32'h0020_0193, 1, 1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_misaligned();
        test_back_to_back();
        test_flush();
        test_timeout();
        test_random();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
